// File: rtl/irq_receiver.sv
// Interrupt receiver: rising-edge capture into pending, masking, fixed lowest-index priority, irq/irq_id/ack handshake.
// Optional lost-interrupt recording is built when IRQ_RECEIVER_OVERFLOW_EN is defined.
module irq_receiver #(
  parameter int NUM_SRC = 4,
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] interrupt_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
`ifdef IRQ_RECEIVER_OVERFLOW_EN
  input  logic               ovf_clr,
  output logic [NUM_SRC-1:0] overflow,
`endif
  input  logic               ack
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] req;
  logic [ID_W-1:0]    low_id;
  logic [ID_W-1:0]    irq_id_nxt;
  logic               irq_nxt;

  assign rise = interrupt_in & ~prev;
  assign req  = pending & mask;
  assign clr  = (state == PRESENT && ack) ? (NUM_SRC'(1) << irq_id) : '0;

  // Highest index scanned first so the lowest set index is the one left standing.
  always_comb begin
    low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    case (state)
      IDLE: begin
        irq_id_nxt = '0;
        if (|req) begin
          state_nxt  = PRESENT;
          irq_id_nxt = low_id;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_nxt  = GAP;
          irq_id_nxt = '0;
        end else if (!mask[irq_id]) begin
          state_nxt  = IDLE;
          irq_id_nxt = '0;
        end
      end
      GAP: begin
        state_nxt  = IDLE;
        irq_id_nxt = '0;
      end
      default: begin
        state_nxt  = IDLE;
        irq_id_nxt = '0;
      end
    endcase
    irq_nxt = (state_nxt == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev    <= '1;
      pending <= '0;
      mask    <= '0;
      state   <= IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
    end else begin
      prev    <= interrupt_in;
      // A same-cycle edge re-sets the bit being acknowledged.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      state   <= state_nxt;
      irq     <= irq_nxt;
      irq_id  <= irq_id_nxt;
    end
  end

`ifdef IRQ_RECEIVER_OVERFLOW_EN
  logic [NUM_SRC-1:0] ovf_set;

  assign ovf_set = rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= '0;
    end else if (ovf_clr) begin
      overflow <= ovf_set;
    end else begin
      overflow <= overflow | ovf_set;
    end
  end
`endif

endmodule

// File: tb/tb_irq_receiver.sv
// Directed bench for irq_receiver (NUM_SRC=4); overflow steps are built only with IRQ_RECEIVER_OVERFLOW_EN.
module tb_irq_receiver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] interrupt_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic [3:0] pending;
  logic       irq;
  logic [1:0] irq_id;
  logic       ack;
`ifdef IRQ_RECEIVER_OVERFLOW_EN
  logic       ovf_clr;
  logic [3:0] overflow;
`endif

  int errors = 0;
  int checks = 0;

  irq_receiver #(.NUM_SRC(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .interrupt_in (interrupt_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .mask         (mask),
    .pending      (pending),
    .irq          (irq),
    .irq_id       (irq_id),
`ifdef IRQ_RECEIVER_OVERFLOW_EN
    .ovf_clr      (ovf_clr),
    .overflow     (overflow),
`endif
    .ack          (ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp_irq, input logic [1:0] exp_id);
    chk({tag, "_irq"}, 16'(irq), 16'(exp_irq));
    chk({tag, "_id"}, 16'(irq_id), 16'(exp_id));
  endtask

  initial begin
    reset_n = 1'b0; interrupt_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0;
`ifdef IRQ_RECEIVER_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    step(); step();
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_mask", 16'(mask), 16'h0);
    chk_irq("rst", 1'b0, 2'd0);
`ifdef IRQ_RECEIVER_OVERFLOW_EN
    chk("rst_ovf", 16'(overflow), 16'h0);
`endif

    reset_n = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    chk("mask_all", 16'(mask), 16'hF);
    step();

    // 1: three-cycle pulse on source 2
    interrupt_in = 4'b0100;
    step();
    chk("t1_pend_k", 16'(pending), 16'h4);
    chk_irq("t1_k", 1'b0, 2'd0);
    step();
    chk_irq("t1_k1", 1'b1, 2'd2);
    step();
    interrupt_in = 4'b0000;
    chk_irq("t1_k2", 1'b1, 2'd2);
    step();
    chk_irq("t1_hold", 1'b1, 2'd2);
    chk("t1_pend_hold", 16'(pending), 16'h4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_irq("t1_ack", 1'b0, 2'd0);
    chk("t1_pend_ack", 16'(pending), 16'h0);
    step(); step();
    chk_irq("t1_quiet", 1'b0, 2'd0);

    // 2: simultaneous sources 1 and 3
    interrupt_in = 4'b1010;
    step();
    interrupt_in = 4'b0000;
    chk("t2_pend", 16'(pending), 16'hA);
    step();
    chk_irq("t2_first", 1'b1, 2'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_irq("t2_gap", 1'b0, 2'd0);
    chk("t2_pend_after1", 16'(pending), 16'h8);
    step();
    chk_irq("t2_idle", 1'b0, 2'd0);
    step();
    chk_irq("t2_second", 1'b1, 2'd3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t2_pend_after2", 16'(pending), 16'h0);
    step(); step();
    chk_irq("t2_quiet", 1'b0, 2'd0);

    // 3: masked source stays pending, unmask presents, mask drop withdraws
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    chk("t3_mask0", 16'(mask), 16'h0);
    interrupt_in = 4'b0001;
    step();
    interrupt_in = 4'b0000;
    chk("t3_pend", 16'(pending), 16'h1);
    step();
    chk_irq("t3_masked", 1'b0, 2'd0);
    mask_we = 1'b1; mask_wdata = 4'b0001;
    step();
    mask_we = 1'b0;
    chk_irq("t3_w", 1'b0, 2'd0);
    step();
    chk_irq("t3_w1", 1'b1, 2'd0);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    chk_irq("t3_drop_w", 1'b1, 2'd0);
    step();
    chk_irq("t3_withdrawn", 1'b0, 2'd0);
    chk("t3_pend_kept", 16'(pending), 16'h1);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    step();
    chk_irq("t3_represent", 1'b1, 2'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_pend_clear", 16'(pending), 16'h0);
    step(); step();

    // 4: ack coincides with a new edge on the presented source
    interrupt_in = 4'b0010;
    step();
    interrupt_in = 4'b0000;
    step();
    chk_irq("t4_present", 1'b1, 2'd1);
    ack = 1'b1; interrupt_in = 4'b0010;
    step();
    ack = 1'b0; interrupt_in = 4'b0000;
    chk("t4_setwins", 16'(pending), 16'h2);
    chk_irq("t4_gap", 1'b0, 2'd0);
    step();
    chk_irq("t4_idle", 1'b0, 2'd0);
    step();
    chk_irq("t4_again", 1'b1, 2'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t4_pend_clear", 16'(pending), 16'h0);
    step(); step();

    // 5: reset mid-handshake with a held-high line
    interrupt_in = 4'b0100;
    step();
    step();
    chk_irq("t5_present", 1'b1, 2'd2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_irq("t5_rst", 1'b0, 2'd0);
    chk("t5_rst_pend", 16'(pending), 16'h0);
    chk("t5_rst_mask", 16'(mask), 16'h0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    chk("t5_nofire", 16'(pending), 16'h0);
    step();
    chk("t5_nofire2", 16'(pending), 16'h0);
    chk_irq("t5_noirq", 1'b0, 2'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t5_ack_pend", 16'(pending), 16'h0);
    chk("t5_ack_mask", 16'(mask), 16'hF);
    chk_irq("t5_ack_irq", 1'b0, 2'd0);
    interrupt_in = 4'b0000;
    step(); step();

`ifdef IRQ_RECEIVER_OVERFLOW_EN
    // 6: second pulse on a still-pending source is recorded, then cleared
    interrupt_in = 4'b0100;
    step();
    interrupt_in = 4'b0000;
    chk("t6_ovf0", 16'(overflow), 16'h0);
    step();
    interrupt_in = 4'b0100;
    step();
    interrupt_in = 4'b0000;
    chk("t6_ovf_set", 16'(overflow), 16'h4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t6_ovf_clr", 16'(overflow), 16'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t6_pend_clear", 16'(pending), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_receiver.md
Name: irq_receiver

Overview:
- Receiving end of the design's interrupt lines. Each source drives a level pulse that is stretched to several cycles.
- The block detects one rising edge per pulse and latches it as pending. It applies a mask, presents the lowest-index unmasked pending source to the CPU with an irq/irq_id/ack handshake, and clears that source on acknowledge.
- Sits between the interrupt generators (video/audio timing blocks) and the CPU interrupt input.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- ID_W, derived localparam = max(1, $clog2(NUM_SRC)), width of irq_id. Not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- interrupt_in  input  NUM_SRC  per-source interrupt lines, synchronous to clk.
- mask_we  input  1  single-cycle write strobe for the mask register.
- mask_wdata  input  NUM_SRC  new mask value (1 = enabled).
- mask  output  NUM_SRC  current mask register.
- pending  output  NUM_SRC  current pending register.
- irq  output  1  interrupt request to the CPU, level.
- irq_id  output  ID_W  index of the presented source; valid while irq=1, 0 otherwise.
- ack  input  1  single-cycle acknowledge from the CPU.

Behaviour:
- Clocking and reset:
  - One clock, clk. reset_n is synchronous and active-low, sampled on the rising edge of clk.
  - While reset_n=0 at an edge: prev<=all ones, pending<=0, mask<=0, state<=IDLE, irq=0, irq_id=0 (and overflow<=0 if the feature is built).
  - Reset wins over every other event, including mid-handshake; no ack is required afterwards.
- Edge detect:
  - edge[i] = interrupt_in[i] & ~prev[i], with prev<=interrupt_in every cycle.
  - Because prev resets to all ones, a line already high at reset release does not fire.
  - A pulse of any length produces exactly one edge.
- Pending register:
  - pending[i] is set on edge[i] regardless of mask.
  - It is cleared only by an accepted ack with irq_id=i.
  - If set and clear coincide on the same source, set wins and pending stays 1.
- Mask:
  - On mask_we, mask<=mask_wdata at that edge.
  - Masked sources stay pending; unmasking later presents them.
- FSM states IDLE, PRESENT, GAP:
  - IDLE: irq=0. If (pending & mask)!=0, latch irq_id = lowest set index and go to PRESENT.
  - PRESENT: irq=1, irq_id frozen.
    - If ack=1: clear pending[irq_id] (subject to set-wins) and go to GAP.
    - Else if mask[irq_id]=0: withdraw, go to IDLE with pending kept, irq=0 next cycle.
    - Ack has priority over a same-cycle mask drop.
  - GAP: irq=0, go to IDLE unconditionally. This guarantees irq is low for at least 2 cycles between requests.
- irq and irq_id are registered outputs.
- Latency: interrupt_in first sampled high at edge k → pending set after k → irq=1 after edge k+1.
- ack in IDLE or GAP is ignored.
- Priority: fixed, lowest index first. It is re-evaluated only in IDLE, so no preemption while in PRESENT.

Optional Feature:
- Macro: IRQ_RECEIVER_OVERFLOW_EN.
- With the macro defined:
  - Adds ports ovf_clr (input 1) and overflow (output NUM_SRC).
  - overflow[i] sets sticky when edge[i] arrives while pending[i]=1 and that bit is not being cleared the same cycle. This records a lost interrupt.
  - ovf_clr=1 clears all overflow bits at that edge; a same-cycle set wins.
  - overflow resets to 0.
- Without the macro: neither port nor its logic exists, and extra edges on a pending source are silently merged.

Test Plan:
1. Reset, mask=4'b1111, 3-cycle pulse on interrupt_in[2] first sampled at edge k → pending=4'b0100 after k, irq=1 with irq_id=2 after k+1, irq stays high until ack.
2. Simultaneous pulses on sources 1 and 3 → irq_id=1.
   - After ack: irq=0 for 2 cycles, then irq=1 with irq_id=3.
   - After second ack: pending=0 and irq stays 0.
3. mask=0, pulse on source 0 → pending=4'b0001, irq=0.
   - mask_we with 4'b0001 at edge w → irq=1 with irq_id=0 after w+1.
   - Writing mask=0 while irq=1 → irq=0 next cycle, pending=4'b0001.
4. ack coincident with a new edge on source 1 while irq_id=1 → pending[1] stays 1, irq drops for the 2 GAP/IDLE cycles, then re-asserts with irq_id=1.
5. reset_n=0 for one cycle while irq=1 → irq=0, pending=0, mask=0 next cycle; a held-high input does not re-fire; ack with irq=0 changes nothing.
6. With IRQ_RECEIVER_OVERFLOW_EN: two pulses on source 2 without ack → overflow=4'b0100; ovf_clr pulse → overflow=0.
